// File: rtl/processors_top.sv
// Alpha-composition streaming engine: blends a latched RGB foreground
// over a generated grayscale pattern, 4 pixels per 128-bit word.
module processors_top #(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 200,
    parameter int STRIPE = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         swInicio,
    input  logic         swInR0,
    input  logic         swInR25,
    input  logic         swInR75,
    input  logic         swInR100,
    input  logic         swInG0,
    input  logic         swInG25,
    input  logic         swInG75,
    input  logic         swInG100,
    input  logic         swInB0,
    input  logic         swInB25,
    input  logic         swInB75,
    input  logic         swInB100,
    input  logic         swTD0,
    input  logic         swTD25,
    input  logic         swTD75,
    input  logic         swTD100,
    input  logic         swH,
    input  logic         swV,
    input  logic         swD,
    input  logic         swP,
    output logic [127:0] GPIO,
    output logic         GPIOEnR,
    output logic         GPIOEnG,
    output logic         GPIOEnB,
    output logic         GPIOEn
);
    localparam int CW = 16;
    localparam int SB = $clog2(STRIPE);
    localparam logic [CW-1:0] XLAST = CW'(IMG_W - 4);
    localparam logic [CW-1:0] YLAST = CW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_R, S_G, S_B, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        P_NONE, P_H, P_V, P_D, P_P
    } pat_t;

    state_t        state_q;
    pat_t          pat_q;
    logic [7:0]    fg_r_q;
    logic [7:0]    fg_g_q;
    logic [7:0]    fg_b_q;
    logic [2:0]    a_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic [127:0]  gpio_q;
    logic          en_q;
    logic          en_r_q;
    logic          en_g_q;
    logic          en_b_q;

    logic [CW-1:0] nx_d;
    logic [CW-1:0] ny_d;
    logic [CW-1:0] cx_d;
    logic [CW-1:0] cy_d;
    logic [7:0]    fg_d;
    logic [127:0]  word_d;
    logic          last_blk_d;

    function automatic logic [7:0] level(
        input logic s0,
        input logic s25,
        input logic s75,
        input logic s100
    );
        logic [7:0] v;
        priority case (1'b1)
            s100:    v = 8'd255;
            s75:     v = 8'd191;
            s25:     v = 8'd64;
            s0:      v = 8'd0;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] weight(
        input logic t0,
        input logic t25,
        input logic t75,
        input logic t100
    );
        logic [2:0] v;
        priority case (1'b1)
            t100:    v = 3'd0;
            t75:     v = 3'd1;
            t25:     v = 3'd3;
            t0:      v = 3'd4;
            default: v = 3'd4;
        endcase
        return v;
    endfunction

    function automatic logic sbit(input logic [CW-1:0] v);
        return |((v >> SB) & CW'(1));
    endfunction

    function automatic logic [7:0] blend(
        input logic [CW-1:0] lx,
        input logic [CW-1:0] ly,
        input logic [7:0]    fg,
        input logic [2:0]    a,
        input pat_t          pat
    );
        logic [7:0] bg;
        logic [9:0] acc;
        bg = 8'd0;
        case (pat)
            P_H:     bg = sbit(ly) ? 8'd0 : 8'd255;
            P_V:     bg = sbit(lx) ? 8'd0 : 8'd255;
            P_D:     bg = sbit(lx + ly) ? 8'd0 : 8'd255;
            P_P:     bg = (sbit(lx) ^ sbit(ly)) ? 8'd0 : 8'd255;
            default: bg = 8'd0;
        endcase
        acc = 10'(a) * 10'(fg) + 10'(3'd4 - a) * 10'(bg);
        return 8'(acc >> 2);
    endfunction

    // Raster advance: next block's coordinates and last-block detect.
    always_comb begin
        last_blk_d = (x_q == XLAST) && (y_q == YLAST);
        nx_d = x_q + CW'(4);
        ny_d = y_q;
        if (x_q == XLAST) begin
            nx_d = '0;
            ny_d = (y_q == YLAST) ? '0 : y_q + CW'(1);
        end
    end

    // Pick the block and channel the upcoming cycle will emit.
    always_comb begin
        cx_d = x_q;
        cy_d = y_q;
        fg_d = fg_r_q;
        case (state_q)
            S_R: fg_d = fg_g_q;
            S_G: fg_d = fg_b_q;
            S_B: begin
                cx_d = nx_d;
                cy_d = ny_d;
            end
            default: fg_d = fg_r_q;
        endcase
    end

    // Four blend lanes shared by the R, G and B cycles.
    always_comb begin
        word_d = '0;
        for (int k = 0; k < 4; k++) begin
            word_d[32*k +: 32] = {24'd0,
                blend(cx_d + CW'(k), cy_d, fg_d, a_q, pat_q)};
        end
    end

    // Frame sequencer with registered word and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= P_NONE;
            fg_r_q  <= '0;
            fg_g_q  <= '0;
            fg_b_q  <= '0;
            a_q     <= 3'd4;
            x_q     <= '0;
            y_q     <= '0;
            gpio_q  <= '0;
            en_q    <= 1'b0;
            en_r_q  <= 1'b0;
            en_g_q  <= 1'b0;
            en_b_q  <= 1'b0;
        end else begin
            gpio_q <= '0;
            en_q   <= 1'b0;
            en_r_q <= 1'b0;
            en_g_q <= 1'b0;
            en_b_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (swInicio) begin
                        fg_r_q <= level(swInR0, swInR25,
                                        swInR75, swInR100);
                        fg_g_q <= level(swInG0, swInG25,
                                        swInG75, swInG100);
                        fg_b_q <= level(swInB0, swInB25,
                                        swInB75, swInB100);
                        a_q <= weight(swTD0, swTD25,
                                      swTD75, swTD100);
                        priority case (1'b1)
                            swH:     pat_q <= P_H;
                            swV:     pat_q <= P_V;
                            swD:     pat_q <= P_D;
                            swP:     pat_q <= P_P;
                            default: pat_q <= P_NONE;
                        endcase
                        x_q     <= '0;
                        y_q     <= '0;
                        en_q    <= 1'b1;
                        state_q <= S_SOF;
                    end
                end
                S_SOF: begin
                    gpio_q  <= word_d;
                    en_r_q  <= 1'b1;
                    state_q <= S_R;
                end
                S_R: begin
                    gpio_q  <= word_d;
                    en_g_q  <= 1'b1;
                    state_q <= S_G;
                end
                S_G: begin
                    gpio_q  <= word_d;
                    en_b_q  <= 1'b1;
                    state_q <= S_B;
                end
                S_B: begin
                    if (last_blk_d) begin
                        state_q <= S_DONE;
                    end else begin
                        x_q     <= nx_d;
                        y_q     <= ny_d;
                        gpio_q  <= word_d;
                        en_r_q  <= 1'b1;
                        state_q <= S_R;
                    end
                end
                S_DONE: begin
                    if (!swInicio) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign GPIO    = gpio_q;
    assign GPIOEn  = en_q;
    assign GPIOEnR = en_r_q;
    assign GPIOEnG = en_g_q;
    assign GPIOEnB = en_b_q;

endmodule

// File: tb/tb_processors_top.sv
// Bench for processors_top: random and directed frames checked
// against a pixel-level reference model of the compositing rules.
module tb_processors_top;
    localparam int W  = 200;
    localparam int H  = 200;
    localparam int ST = 8;
    localparam int NB = W * H / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         swInicio = 1'b0;
    logic [3:0]   swR = 4'b1000;
    logic [3:0]   swG = 4'b1000;
    logic [3:0]   swB = 4'b1000;
    logic [3:0]   swTD = 4'b0100;
    logic [3:0]   swPat = 4'b0100;
    logic [127:0] GPIO;
    logic         GPIOEnR;
    logic         GPIOEnG;
    logic         GPIOEnB;
    logic         GPIOEn;

    // latched copy of the configuration, as the model sees it
    logic [3:0] cR, cG, cB, cTD, cPat;

    int tests = 0;
    int fails = 0;

    processors_top #(.IMG_W(W), .IMG_H(H), .STRIPE(ST)) dut (
        .clk(clk), .rst(rst), .swInicio(swInicio),
        .swInR0(swR[0]), .swInR25(swR[1]),
        .swInR75(swR[2]), .swInR100(swR[3]),
        .swInG0(swG[0]), .swInG25(swG[1]),
        .swInG75(swG[2]), .swInG100(swG[3]),
        .swInB0(swB[0]), .swInB25(swB[1]),
        .swInB75(swB[2]), .swInB100(swB[3]),
        .swTD0(swTD[0]), .swTD25(swTD[1]),
        .swTD75(swTD[2]), .swTD100(swTD[3]),
        .swH(swPat[0]), .swV(swPat[1]),
        .swD(swPat[2]), .swP(swPat[3]),
        .GPIO(GPIO), .GPIOEnR(GPIOEnR), .GPIOEnG(GPIOEnG),
        .GPIOEnB(GPIOEnB), .GPIOEn(GPIOEn)
    );

    always #5 clk = ~clk;

    function automatic int lvl(input logic [3:0] s);
        if (s[3]) return 255;
        if (s[2]) return 191;
        if (s[1]) return 64;
        return 0;
    endfunction

    function automatic int wgt(input logic [3:0] s);
        if (s[3]) return 0;
        if (s[2]) return 1;
        if (s[1]) return 3;
        return 4;
    endfunction

    function automatic int bgv(input int x, input int y,
                               input logic [3:0] p);
        int b;
        if (p[0]) b = (y / ST) % 2;
        else if (p[1]) b = (x / ST) % 2;
        else if (p[2]) b = ((x + y) / ST) % 2;
        else if (p[3]) b = ((x / ST) + (y / ST)) % 2;
        else return 0;
        return (b != 0) ? 0 : 255;
    endfunction

    function automatic logic [127:0] exp_word(input int blk,
                                              input int ch);
        logic [127:0] w;
        int fg, a, x0, y, v;
        fg = (ch == 0) ? lvl(cR) : (ch == 1) ? lvl(cG) : lvl(cB);
        a  = wgt(cTD);
        x0 = (4 * blk) % W;
        y  = (4 * blk) / W;
        w  = '0;
        for (int k = 0; k < 4; k++) begin
            v = (a * fg + (4 - a) * bgv(x0 + k, y, cPat)) / 4;
            w[32*k +: 32] = 32'(v);
        end
        return w;
    endfunction

    task automatic latch_cfg();
        cR = swR; cG = swG; cB = swB; cTD = swTD; cPat = swPat;
    endtask

    task automatic quiet(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB} !== 4'b0 ||
                GPIO !== 128'd0) begin
                fails++;
                $display("FAIL %s cyc%0d: en=%b gpio=%h, want 0",
                         nm, i, {GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB},
                         GPIO);
            end
        end
    endtask

    task automatic start_frame(input string nm);
        bit seen;
        latch_cfg();
        swInicio = 1'b1;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk); #1;
            if (GPIOEn === 1'b1) seen = 1;
        end
        tests++;
        if (!seen || {GPIOEnR, GPIOEnG, GPIOEnB} !== 3'b0 ||
            GPIO !== 128'd0) begin
            fails++;
            $display("FAIL %s sof: seen=%0d en=%b gpio=%h, want 1/000/0",
                     nm, seen, {GPIOEnR, GPIOEnG, GPIOEnB}, GPIO);
        end
    endtask

    task automatic run_blocks(input int nb, input string nm);
        logic [3:0]   want_en;
        logic [127:0] want;
        for (int b = 0; b < nb; b++) begin
            for (int ch = 0; ch < 3; ch++) begin
                @(posedge clk); #1;
                want_en = 4'b0100 >> ch;
                want = exp_word(b, ch);
                tests++;
                if ({GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB} !== want_en ||
                    GPIO !== want) begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL %s b%0d ch%0d: en=%b gpio=%h, want en=%b gpio=%h",
                                 nm, b, ch,
                                 {GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB},
                                 GPIO, want_en, want);
                end
            end
        end
    endtask

    task automatic abort_frame();
        swInicio = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        swInicio = 1'b1;
        @(posedge clk); #1;
        quiet(4, "reset");
        latch_cfg();
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (GPIOEn !== 1'b1 || GPIO !== 128'd0) begin
            fails++;
            $display("FAIL reset_release: GPIOEn=%b gpio=%h, want 1/0",
                     GPIOEn, GPIO);
        end
        abort_frame();
    endtask

    task automatic test_defaults();
        swR = 4'b1000; swG = 4'b1000; swB = 4'b1000;
        swTD = 4'b0100; swPat = 4'b0100;
        start_frame("defaults");
        run_blocks(NB, "defaults");
        quiet(6, "done_hold");
        swInicio = 1'b0;
        quiet(1, "done_exit");
        start_frame("restart");
        abort_frame();
    endtask

    task automatic test_td0_h();
        swR = 4'b1000; swG = 4'b0001; swB = 4'b0010;
        swTD = 4'b0001; swPat = 4'b0001;
        start_frame("td0_h");
        run_blocks(NB, "td0_h");
        quiet(2, "td0_h_end");
        abort_frame();
    endtask

    task automatic test_td100_p();
        swR = 4'($urandom); swG = 4'($urandom); swB = 4'($urandom);
        swTD = 4'b1000; swPat = 4'b1000;
        start_frame("td100_p");
        run_blocks(8 * (W / 4) + 3, "td100_p");
        abort_frame();
    endtask

    task automatic test_priority();
        swR = 4'b1001; swG = 4'b0000;
        swB = 4'($urandom_range(1, 15));
        swTD = 4'b0000;
        swPat = 4'($urandom);
        start_frame("priority");
        run_blocks(60, "priority");
        abort_frame();
    endtask

    task automatic test_reset_mid();
        swR = 4'b0100; swG = 4'b0010; swB = 4'b1000;
        swTD = 4'b0010; swPat = 4'b0010;
        start_frame("rst_mid");
        run_blocks(3, "rst_mid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (GPIOEnG !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_g: GPIOEnG=%b, want 1", GPIOEnG);
        end
        rst = 1'b1;
        quiet(1, "rst_mid_off");
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (GPIOEn !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_sof: GPIOEn=%b, want 1", GPIOEn);
        end
        run_blocks(4, "rst_mid_again");
        abort_frame();
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            swR = 4'($urandom); swG = 4'($urandom);
            swB = 4'($urandom); swTD = 4'($urandom);
            swPat = 4'($urandom);
            start_frame("random");
            swR = 4'($urandom); swTD = 4'($urandom);
            swPat = 4'($urandom);
            run_blocks(120, "random");
            abort_frame();
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_td0_h();
        test_td100_p();
        test_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
